retire_monitor: RTL and testbench

Commit-stream checker and waveform-dump controller for the RV32IM out-of-order core's Verilator bench. It sits directly downstream of the DUT's in-order retire port and consumes one retired instruction per cycle. It checks ordering, PC continuity and traps, and detects the end-of-program halt. It produces the `dump_on`, halt and error signals that the top-level testbench exports and uses to stop simulation.

---
 rtl/retire_monitor.sv | 170 +++++++++++++++++
 tb/tb_retire_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_monitor.sv
`default_nettype none
// ============================================================================
// retire_monitor : in-order retire-stream checker, halt detector, dump control
// Optional idle watchdog enabled by defining RETIRE_MON_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
module retire_monitor #(
  parameter logic [63:0] DUMP_START      = 64'd0,
  parameter logic [63:0] DUMP_LEN        = 64'd0,
  parameter logic [31:0] HALT_INSN       = 32'h0000006f,
  parameter int unsigned DRAIN_CYCLES    = 8,
  parameter int unsigned WATCHDOG_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [63:0] order,
  input  logic [31:0] insn,
  input  logic [31:0] pc_rdata,
  input  logic [31:0] pc_wdata,
  input  logic        trap,
  output logic        dump_on,
  output logic        halt,
  output logic        error,
  output logic [2:0]  error_code,
  output logic [63:0] commit_count,
  output logic [63:0] cycle_count
);

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_ORDER     = 3'd1;
  localparam logic [2:0] ERR_TRAP      = 3'd2;
  localparam logic [2:0] ERR_PC        = 3'd3;
  localparam logic [2:0] ERR_POST_HALT = 3'd4;
  localparam logic [2:0] ERR_WATCHDOG  = 3'd5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [63:0] exp_order;
  logic        first;
  logic [31:0] prev_pc;
  logic [7:0]  drain_cnt;

  logic        err_order;
  logic        err_trap;
  logic        err_pc;
  logic        err_post;
  logic        wd_fire;
  logic        err_any;
  logic [2:0]  err_code_nx;
  logic        is_halt;
  logic        count_en;
  logic [63:0] commit_nx;
  logic        dump_nx;
  logic        halt_nx;

  always_comb begin
    err_order   = 1'b0;
    err_trap    = 1'b0;
    err_pc      = 1'b0;
    err_post    = 1'b0;
    err_code_nx = ERR_NONE;
    state_nx    = state;

    if (state == RUN && valid) begin
      err_order = (order != exp_order);
      err_trap  = trap;
      err_pc    = !first && (pc_rdata != prev_pc);
    end
    if (state == DRAIN && valid) begin
      err_post = 1'b1;
    end

    err_any = err_order | err_trap | err_pc | err_post | wd_fire;

    // Lowest code wins when several checks fire together.
    if (err_order)     err_code_nx = ERR_ORDER;
    else if (err_trap) err_code_nx = ERR_TRAP;
    else if (err_pc)   err_code_nx = ERR_PC;
    else if (err_post) err_code_nx = ERR_POST_HALT;
    else if (wd_fire)  err_code_nx = ERR_WATCHDOG;

    is_halt = (state == RUN) && valid && (insn == HALT_INSN) &&
              (pc_wdata == pc_rdata) && !err_any;

    case (state)
      RUN: begin
        if (err_any)      state_nx = DONE;
        else if (is_halt) state_nx = DRAIN;
      end
      DRAIN: begin
        if (err_any || drain_cnt == 8'd1) state_nx = DONE;
      end
      default: state_nx = DONE;
    endcase

    count_en  = valid && (state != DONE);
    commit_nx = commit_count + {63'd0, count_en};
    dump_nx   = (state_nx != DONE) && (commit_nx >= DUMP_START) &&
                ((DUMP_LEN == 64'd0) || (commit_nx < DUMP_START + DUMP_LEN));
    // A clean drain reports halt one cycle after reaching DONE; errors report at once.
    halt_nx   = (state == DONE) || err_any;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= RUN;
      exp_order    <= 64'd0;
      first        <= 1'b1;
      prev_pc      <= 32'd0;
      drain_cnt    <= 8'd0;
      dump_on      <= 1'b0;
      halt         <= 1'b0;
      error        <= 1'b0;
      error_code   <= ERR_NONE;
      commit_count <= 64'd0;
      cycle_count  <= 64'd0;
    end else begin
      state        <= state_nx;
      dump_on      <= dump_nx;
      halt         <= halt_nx;
      commit_count <= commit_nx;
      if (state != DONE) begin
        cycle_count <= cycle_count + 64'd1;
      end
      if (state == RUN && valid) begin
        exp_order <= exp_order + 64'd1;
        prev_pc   <= pc_wdata;
        first     <= 1'b0;
      end
      if (is_halt) begin
        drain_cnt <= 8'(DRAIN_CYCLES);
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt - 8'd1;
      end
      if (err_any && !error) begin
        error      <= 1'b1;
        error_code <= err_code_nx;
      end
    end
  end

`ifdef RETIRE_MON_WATCHDOG_EN
  logic [31:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_cnt <= 32'd0;
    end else if (state == RUN) begin
      if (valid) begin
        idle_cnt <= 32'd0;
      end else if (idle_cnt != 32'(WATCHDOG_CYCLES)) begin
        idle_cnt <= idle_cnt + 32'd1;
      end
    end
  end

  assign wd_fire = (state == RUN) && !valid && (idle_cnt == 32'(WATCHDOG_CYCLES));
`else
  assign wd_fire = 1'b0 & (WATCHDOG_CYCLES == 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_retire_monitor.sv
`default_nettype none
// tb_retire_monitor : directed stimulus with a due-cycle scoreboard checked on
// the falling edge; a second instance covers a bounded dump window.
module tb_retire_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [63:0] order;
  logic [31:0] insn;
  logic [31:0] pc_rdata;
  logic [31:0] pc_wdata;
  logic        trap;

  logic        dump_on, halt, error;
  logic [2:0]  error_code;
  logic [63:0] commit_count, cycle_count;
  logic        dump_on_b, halt_b, error_b;
  logic [2:0]  error_code_b;
  logic [63:0] commit_count_b, cycle_count_b;

  always #5 clk = ~clk;

  retire_monitor #(
    .DUMP_START(64'd0), .DUMP_LEN(64'd0), .HALT_INSN(32'h0000006f),
    .DRAIN_CYCLES(8), .WATCHDOG_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .order(order), .insn(insn),
    .pc_rdata(pc_rdata), .pc_wdata(pc_wdata), .trap(trap),
    .dump_on(dump_on), .halt(halt), .error(error), .error_code(error_code),
    .commit_count(commit_count), .cycle_count(cycle_count)
  );

  retire_monitor #(
    .DUMP_START(64'd3), .DUMP_LEN(64'd2), .HALT_INSN(32'h0000006f),
    .DRAIN_CYCLES(8), .WATCHDOG_CYCLES(16)
  ) dut_b (
    .clk(clk), .rst(rst), .valid(valid), .order(order), .insn(insn),
    .pc_rdata(pc_rdata), .pc_wdata(pc_wdata), .trap(trap),
    .dump_on(dump_on_b), .halt(halt_b), .error(error_b), .error_code(error_code_b),
    .commit_count(commit_count_b), .cycle_count(cycle_count_b)
  );

  localparam int S_DUMP = 0, S_HALT = 1, S_ERR = 2, S_CODE = 3, S_CCNT = 4, S_CYC = 5;
  localparam int S_DUMPB = 6, S_HALTB = 7, S_ERRB = 8, S_CODEB = 9, S_CCNTB = 10, S_CYCB = 11;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] HALT = 32'h0000006f;

  typedef struct {
    int          due;
    int          sel;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   edgecnt = 0;
  int   checks  = 0;
  int   errors  = 0;
  logic flush   = 1'b0;

  always @(posedge clk) edgecnt <= edgecnt + 1;

  function automatic logic [63:0] probe(int sel);
    case (sel)
      S_DUMP:  return {63'd0, dump_on};
      S_HALT:  return {63'd0, halt};
      S_ERR:   return {63'd0, error};
      S_CODE:  return {61'd0, error_code};
      S_CCNT:  return commit_count;
      S_CYC:   return cycle_count;
      S_DUMPB: return {63'd0, dump_on_b};
      S_HALTB: return {63'd0, halt_b};
      S_ERRB:  return {63'd0, error_b};
      S_CODEB: return {61'd0, error_code_b};
      S_CCNTB: return commit_count_b;
      default: return cycle_count_b;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    int k;
    k = 0;
    while (k < sb.size()) begin
      if (flush) begin
        checks++;
        errors++;
        $display("FAIL %s never checked (due edge %0d, now %0d) expected %0h",
                 sb[k].name, sb[k].due, edgecnt, sb[k].exp);
        sb.delete(k);
      end else if (sb[k].due == edgecnt) begin
        checks++;
        if (probe(sb[k].sel) !== sb[k].exp) begin
          errors++;
          $display("FAIL %s at edge %0d: got %0h expected %0h",
                   sb[k].name, edgecnt, probe(sb[k].sel), sb[k].exp);
        end
        sb.delete(k);
      end else begin
        k++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(int d, int sel, logic [63:0] v, string nm);
    chk_t c;
    c.due  = edgecnt + d;
    c.sel  = sel;
    c.exp  = v;
    c.name = nm;
    sb.push_back(c);
  endtask

  task automatic idle();
    valid = 1'b0;
    trap  = 1'b0;
  endtask

  task automatic commit(logic [63:0] o, logic [31:0] ins, logic [31:0] pr,
                        logic [31:0] pw, logic tr);
    valid    = 1'b1;
    order    = o;
    insn     = ins;
    pc_rdata = pr;
    pc_wdata = pw;
    trap     = tr;
  endtask

  task automatic do_reset(int n);
    rst = 1'b0;
    idle();
    repeat (n) step();
    rst = 1'b1;
    for (int s = S_DUMP; s <= S_CYC; s++) begin
      expect_at(0, s, 64'd0, $sformatf("reset_sel%0d", s));
    end
  endtask

  logic [0:5] exp_dump_b;

  initial begin
    rst = 1'b0; valid = 1'b0; trap = 1'b0; order = '0; insn = '0;
    pc_rdata = '0; pc_wdata = '0;
    exp_dump_b = 6'b001100;

    // Clean 10-commit stream followed by the halt idiom.
    do_reset(2);
    expect_at(0, S_DUMPB, 64'd0, "reset_dump_b");
    expect_at(1, S_DUMP, 64'd1, "dump_on_start0");
    expect_at(1, S_CYC, 64'd1, "cycle_first");
    for (int i = 0; i < 10; i++) begin
      commit(64'(i), NOP, 32'h60000000 + 32'(4 * i), 32'h60000004 + 32'(4 * i), 1'b0);
      expect_at(1, S_CCNT, 64'(i + 1), "commit_count_stream");
      if (i < 6) expect_at(1, S_DUMPB, {63'd0, exp_dump_b[i]}, $sformatf("dump_b_after_%0d", i + 1));
      step();
    end
    commit(64'd10, HALT, 32'h60000028, 32'h60000028, 1'b0);
    expect_at(1, S_CCNT, 64'd11, "halt_commit_counted");
    expect_at(8, S_DUMP, 64'd1, "dump_in_drain");
    expect_at(9, S_DUMP, 64'd0, "dump_off_done");
    expect_at(9, S_HALT, 64'd0, "halt_not_early");
    expect_at(10, S_HALT, 64'd1, "halt_rise");
    expect_at(10, S_ERR, 64'd0, "no_error_stream");
    expect_at(10, S_CODE, 64'd0, "no_code_stream");
    expect_at(12, S_CYC, 64'd19, "cycle_frozen");
    expect_at(12, S_CCNT, 64'd11, "commit_frozen");
    expect_at(12, S_HALTB, 64'd1, "halt_b");
    expect_at(12, S_ERRB, 64'd0, "error_b");
    expect_at(12, S_CODEB, 64'd0, "code_b");
    expect_at(12, S_CCNTB, 64'd11, "commit_b");
    expect_at(12, S_CYCB, 64'd19, "cycle_b");
    step();
    idle();
    repeat (12) step();

    // Order gap, then a trap that must not overwrite the first code.
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      commit(64'(i), NOP, 32'h1000 + 32'(4 * i), 32'h1004 + 32'(4 * i), 1'b0);
      if (i == 3) expect_at(1, S_ERR, 64'd0, "no_error_before_gap");
      step();
    end
    commit(64'd5, NOP, 32'h1010, 32'h1014, 1'b0);
    expect_at(1, S_ERR, 64'd1, "order_error");
    expect_at(1, S_CODE, 64'd1, "order_code");
    expect_at(1, S_HALT, 64'd1, "order_halt");
    expect_at(1, S_CCNT, 64'd5, "error_commit_counted");
    step();
    commit(64'd6, NOP, 32'h2000, 32'h2004, 1'b1);
    expect_at(1, S_CODE, 64'd1, "code_sticky");
    expect_at(1, S_CCNT, 64'd5, "done_ignores_valid");
    step();
    idle();
    step();

    // Trap and PC mismatch together: trap code wins.
    do_reset(1);
    commit(64'd0, NOP, 32'h3000, 32'h3004, 1'b0);
    step();
    commit(64'd1, NOP, 32'h3008, 32'h300c, 1'b1);
    expect_at(1, S_CODE, 64'd2, "trap_over_pc");
    expect_at(1, S_ERR, 64'd1, "trap_error");
    step();
    idle();
    step();

    // PC discontinuity alone.
    do_reset(1);
    commit(64'd0, NOP, 32'h3000, 32'h3004, 1'b0);
    step();
    commit(64'd1, NOP, 32'h3010, 32'h3014, 1'b0);
    expect_at(1, S_CODE, 64'd3, "pc_code");
    step();
    idle();
    step();

    // Commit during drain, then a one-edge reset out of DONE.
    do_reset(1);
    commit(64'd0, HALT, 32'h100, 32'h100, 1'b0);
    step();
    idle();
    step();
    commit(64'd1, NOP, 32'h104, 32'h108, 1'b0);
    expect_at(1, S_CODE, 64'd4, "post_halt_code");
    expect_at(1, S_ERR, 64'd1, "post_halt_error");
    expect_at(1, S_HALT, 64'd1, "post_halt_halt");
    step();
    idle();
    step();
    do_reset(1);
    commit(64'd0, NOP, 32'h200, 32'h204, 1'b0);
    expect_at(1, S_CCNT, 64'd1, "run_after_reset");
    expect_at(1, S_ERR, 64'd0, "clean_after_reset");
    expect_at(1, S_DUMP, 64'd1, "dump_after_reset");
    step();
    idle();
    step();

    // Idle stream.
    do_reset(1);
`ifdef RETIRE_MON_WATCHDOG_EN
    expect_at(16, S_CODE, 64'd0, "wd_not_early");
    expect_at(16, S_HALT, 64'd0, "wd_halt_not_early");
    expect_at(17, S_CODE, 64'd5, "wd_code");
    expect_at(17, S_HALT, 64'd1, "wd_halt");
    repeat (20) step();
`else
    expect_at(1000, S_ERR, 64'd0, "idle_no_error");
    expect_at(1000, S_HALT, 64'd0, "idle_no_halt");
    expect_at(1000, S_CODE, 64'd0, "idle_no_code");
    expect_at(1000, S_CYC, 64'd1000, "idle_cycles");
    repeat (1001) step();
`endif

    repeat (2) step();
    flush = 1'b1;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
